uart_axis_bridge: RTL and testbench

- Byte-serial front end for the Wishbone-over-AXIS command engine.
- UART RX deserializes host bytes onto an AXIS master that feeds the engine's command input.
- UART TX serializes the engine's response AXIS stream back to the host.
- Fixed 8N1 framing, LSB first; baud set by an integer clock divider.

---
 rtl/uart_axis_bridge_if.sv | 25 ++
 rtl/uart_axis_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_axis_bridge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axis_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_axis_bridge_if
//
// Purpose : Byte-wide AXI-Stream link used on both sides of uart_axis_bridge.
//           The bridge drives one instance as master (received bytes towards
//           the command engine) and consumes another as slave (response bytes
//           from the engine).
//
// Signals : tdata  [7:0]  byte payload
//           tvalid        payload valid
//           tready        sink accepts payload
//           tlast         end of packet (not used for framing by the bridge)
//
// Modports: master - drives tdata/tvalid/tlast, observes tready
//           slave  - observes tdata/tvalid/tlast, drives tready
// -----------------------------------------------------------------------------
interface uart_axis_bridge_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/uart_axis_bridge.sv
// -----------------------------------------------------------------------------
// uart_axis_bridge
//
// Purpose : Byte-serial front end for the Wishbone-over-AXIS command engine.
//           A UART receiver deserializes host bytes into a one-entry holding
//           register presented on m_axis; a UART transmitter serializes the
//           engine's response bytes taken from s_axis. Framing is 8N1, LSB
//           first, with the bit time set by the integer divider BAUD_DIV
//           (minimum 4). RX and TX run fully independently.
//
// Optional: define UART_PARITY_EN to insert an even-parity bit after data
//           bit 7 in both directions (8E1). Undefined: 8N1, rx_parity_err = 0.
//
// Ports   : clk            system clock
//           rst            asynchronous, active-high reset
//           uart_rxd       serial receive line (asynchronous, idle high)
//           uart_txd       serial transmit line (registered, idle high)
//           m_axis         master: received bytes, tlast tied 0
//           s_axis         slave : bytes to transmit, tlast ignored
//           rx_overrun     1-cycle pulse: byte dropped, holding register full
//           rx_frame_err   1-cycle pulse: stop bit sampled low
//           rx_parity_err  1-cycle pulse: parity mismatch (0 without option)
//           tx_busy        high from byte acceptance to end of stop bit
// -----------------------------------------------------------------------------
module uart_axis_bridge #(
    parameter int BAUD_DIV = 868
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    output logic               uart_txd,
    uart_axis_bridge_if.master m_axis,
    uart_axis_bridge_if.slave  s_axis,
    output logic               rx_overrun,
    output logic               rx_frame_err,
    output logic               rx_parity_err,
    output logic               tx_busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        R_WAIT_HIGH,
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_PARITY,
        T_STOP
    } tx_state_t;

    // ------------------------------------------------------------------------
    // RX synchronizer: flops reset to the idle (high) line level so a reset
    // never looks like a start bit.
    // ------------------------------------------------------------------------
    logic [1:0] rx_sync_q;
    logic       rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rxd};
        end
    end

    assign rxd_s = rx_sync_q[1];

    // ------------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------------
    rx_state_t      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic           rx_deliver;
    logic           rx_ferr_d;
    logic           rx_perr_d;
`ifdef UART_PARITY_EN
    logic           rx_par_q, rx_par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= R_WAIT_HIGH;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_deliver = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_perr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        case (rx_state_q)
            R_WAIT_HIGH: begin
                if (rxd_s) rx_state_d = R_IDLE;
            end
            R_IDLE: begin
                if (!rxd_s) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                end
            end
            R_START: begin
                // Re-check the start bit mid-way; a high line here is a glitch.
                if (rx_cnt_q == BAUD_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                // Counter was re-based at mid start bit, so BAUD_LAST lands
                // in the middle of each data bit.
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = R_PARITY;
`else
                        rx_state_d = R_STOP;
`endif
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            R_PARITY: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rxd_s;
                    rx_state_d = R_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
`endif
            R_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d = '0;
                    if (!rxd_s) begin
                        // Bad stop bit (or break): wait for the line to
                        // return high before hunting for a new start bit.
                        rx_ferr_d  = 1'b1;
                        rx_state_d = R_WAIT_HIGH;
                    end else begin
                        rx_state_d = R_IDLE;
`ifdef UART_PARITY_EN
                        if ((^rx_shift_q) ^ rx_par_q) begin
                            rx_perr_d = 1'b1;
                        end else begin
                            rx_deliver = 1'b1;
                        end
`else
                        rx_deliver = 1'b1;
`endif
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = R_WAIT_HIGH;
        endcase
    end

    // ------------------------------------------------------------------------
    // RX holding register and status pulses. A handshake in the delivery
    // cycle frees the slot, so the new byte loads instead of overrunning.
    // ------------------------------------------------------------------------
    logic [7:0] m_tdata_q;
    logic       m_tvalid_q;
    logic       m_full;
    logic       ovr_q, ferr_q, perr_q;

    assign m_full = m_tvalid_q && !m_axis.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            ovr_q  <= rx_deliver && m_full;
            ferr_q <= rx_ferr_d;
            perr_q <= rx_perr_d;
            if (rx_deliver && !m_full) begin
                m_tdata_q  <= rx_shift_q;
                m_tvalid_q <= 1'b1;
            end else if (m_tvalid_q && m_axis.tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = 1'b0;
    assign rx_overrun    = ovr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_q;

    // ------------------------------------------------------------------------
    // TX FSM. txd and tready are registered; tready is held low in reset and
    // follows "next state is idle" so it drops the cycle after acceptance.
    // ------------------------------------------------------------------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             tready_q, tready_d;
    logic             tx_hs;
    logic             unused_tlast;
`ifdef UART_PARITY_EN
    logic             tx_par_q, tx_par_d;
`endif

    assign unused_tlast = s_axis.tlast;
    assign tx_hs        = s_axis.tvalid && tready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tready_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tready_q   <= tready_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            T_IDLE: begin
                txd_d = 1'b1;
                if (tx_hs) begin
                    tx_state_d = T_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = s_axis.tdata;
                    txd_d      = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^s_axis.tdata;
`endif
                end
            end
            T_START: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_state_d = T_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            T_DATA: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = T_PARITY;
                        txd_d      = tx_par_q;
`else
                        tx_state_d = T_STOP;
                        txd_d      = 1'b1;
`endif
                    end else begin
                        txd_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            T_PARITY: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_state_d = T_STOP;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`endif
            T_STOP: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_state_d = T_IDLE;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = T_IDLE;
                txd_d      = 1'b1;
            end
        endcase
        tready_d = (tx_state_d == T_IDLE);
    end

    assign uart_txd      = txd_q;
    assign s_axis.tready = tready_q;
    assign tx_busy       = (tx_state_q != T_IDLE);

endmodule

// File: tb/tb_uart_axis_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_axis_bridge
//
// Directed bench for uart_axis_bridge at BAUD_DIV=8: RX delivery and
// holding, TX bit timing, overrun, frame error/break, start-bit glitch,
// asynchronous reset mid-frame, and TX->RX loopback (with the parity
// cases when UART_PARITY_EN is defined).
// -----------------------------------------------------------------------------
module tb_uart_axis_bridge;

    localparam int BAUD = 8;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_drv = 1'b1;
    logic lb_en = 1'b0;
    logic uart_rxd;
    logic uart_txd;
    logic rx_overrun;
    logic rx_frame_err;
    logic rx_parity_err;
    logic tx_busy;

    uart_axis_bridge_if m_axis_if ();
    uart_axis_bridge_if s_axis_if ();

    assign uart_rxd = lb_en ? uart_txd : rxd_drv;

    uart_axis_bridge #(.BAUD_DIV(BAUD)) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rxd      (uart_rxd),
        .uart_txd      (uart_txd),
        .m_axis        (m_axis_if),
        .s_axis        (s_axis_if),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_overrun)    ovr_cnt  = ovr_cnt + 1;
        if (rx_frame_err)  ferr_cnt = ferr_cnt + 1;
        if (rx_parity_err) perr_cnt = perr_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one complete frame on rxd with correct parity (if compiled in).
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (BAUD) tick();
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (BAUD) tick();
        end
`ifdef UART_PARITY_EN
        rxd_drv = ^b;
        repeat (BAUD) tick();
`endif
        rxd_drv = stop_bit;
        repeat (BAUD) tick();
        rxd_drv = 1'b1;
    endtask

    task automatic flush_rx();
        m_axis_if.tready = 1'b1;
        tick();
        m_axis_if.tready = 1'b0;
    endtask

    initial begin
        int ovr0;
        int ferr0;
        int perr0;
        logic [FRAME_BITS-1:0] tx_exp;

        m_axis_if.tready = 1'b0;
        s_axis_if.tdata  = 8'h00;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_txd", uart_txd, 1'b1);
        chk1("rst_tvalid", m_axis_if.tvalid, 1'b0);
        chk8("rst_tdata", m_axis_if.tdata, 8'h00);
        chk1("rst_tready", s_axis_if.tready, 1'b0);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_ovr", rx_overrun, 1'b0);
        chk1("rst_ferr", rx_frame_err, 1'b0);
        chk1("rst_perr", rx_parity_err, 1'b0);
        chk1("rst_tlast", m_axis_if.tlast, 1'b0);
        rst = 1'b0;
        repeat (4) tick();
        chk1("idle_tready", s_axis_if.tready, 1'b1);

        // RX 0xA5 held while tready=0, then handshake
        ferr0 = ferr_cnt;
        send_rx(8'hA5, 1'b1);
        chk1("a5_tvalid", m_axis_if.tvalid, 1'b1);
        chk8("a5_tdata", m_axis_if.tdata, 8'hA5);
        repeat (20) tick();
        chk1("a5_hold_tvalid", m_axis_if.tvalid, 1'b1);
        chk8("a5_hold_tdata", m_axis_if.tdata, 8'hA5);
        chkn("a5_no_ferr", ferr_cnt - ferr0, 0);
        flush_rx();
        chk1("a5_cleared", m_axis_if.tvalid, 1'b0);

        // TX 0x3C bit timing
`ifdef UART_PARITY_EN
        tx_exp = 11'b10001111000;
`else
        tx_exp = 10'b1001111000;
`endif
        s_axis_if.tdata  = 8'h3C;
        s_axis_if.tvalid = 1'b1;
        tick();
        s_axis_if.tvalid = 1'b0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int j = 0; j < BAUD; j++) begin
                chk1("tx3c_txd", uart_txd, tx_exp[i]);
                chk1("tx3c_busy", tx_busy, 1'b1);
                chk1("tx3c_tready", s_axis_if.tready, 1'b0);
                tick();
            end
        end
        chk1("tx3c_end_txd", uart_txd, 1'b1);
        chk1("tx3c_end_busy", tx_busy, 1'b0);
        chk1("tx3c_end_tready", s_axis_if.tready, 1'b1);

        // Overrun: 0x11 then 0x22 with tready=0
        ovr0 = ovr_cnt;
        send_rx(8'h11, 1'b1);
        repeat (4) tick();
        send_rx(8'h22, 1'b1);
        repeat (4) tick();
        chk1("ovr_tvalid", m_axis_if.tvalid, 1'b1);
        chk8("ovr_tdata", m_axis_if.tdata, 8'h11);
        chkn("ovr_pulses", ovr_cnt - ovr0, 1);
        flush_rx();
        chk1("ovr_cleared", m_axis_if.tvalid, 1'b0);

        // Frame error followed by break, then a good frame
        ferr0 = ferr_cnt;
        send_rx(8'h55, 1'b0);
        rxd_drv = 1'b0;
        repeat (40) tick();
        rxd_drv = 1'b1;
        repeat (10) tick();
        chkn("ferr_pulses", ferr_cnt - ferr0, 1);
        chk1("ferr_no_tvalid", m_axis_if.tvalid, 1'b0);
        send_rx(8'h55, 1'b1);
        repeat (4) tick();
        chk1("ferr_next_tvalid", m_axis_if.tvalid, 1'b1);
        chk8("ferr_next_tdata", m_axis_if.tdata, 8'h55);
        chkn("ferr_next_pulses", ferr_cnt - ferr0, 1);
        flush_rx();

        // Start-bit glitch of 2 cycles
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
        perr0 = perr_cnt;
        rxd_drv = 1'b0;
        repeat (2) tick();
        rxd_drv = 1'b1;
        repeat (20) tick();
        chk1("glitch_tvalid", m_axis_if.tvalid, 1'b0);
        chkn("glitch_ferr", ferr_cnt - ferr0, 0);
        chkn("glitch_ovr", ovr_cnt - ovr0, 0);
        chkn("glitch_perr", perr_cnt - perr0, 0);

        // Async reset mid RX and mid TX frame
        send_rx(8'h5A, 1'b1);
        repeat (4) tick();
        chk1("pre_rst_tvalid", m_axis_if.tvalid, 1'b1);
        s_axis_if.tdata  = 8'h00;
        s_axis_if.tvalid = 1'b1;
        tick();
        s_axis_if.tvalid = 1'b0;
        chk1("pre_rst_txd", uart_txd, 1'b0);
        rxd_drv = 1'b0;
        repeat (4 * BAUD) tick();
        rst = 1'b1;
        #1;
        chk1("mid_rst_tvalid", m_axis_if.tvalid, 1'b0);
        chk8("mid_rst_tdata", m_axis_if.tdata, 8'h00);
        chk1("mid_rst_txd", uart_txd, 1'b1);
        chk1("mid_rst_tready", s_axis_if.tready, 1'b0);
        chk1("mid_rst_busy", tx_busy, 1'b0);
        rxd_drv = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk1("post_rst_tready", s_axis_if.tready, 1'b1);
        chk1("post_rst_txd", uart_txd, 1'b1);
        send_rx(8'h96, 1'b1);
        repeat (4) tick();
        chk1("post_rst_tvalid", m_axis_if.tvalid, 1'b1);
        chk8("post_rst_tdata", m_axis_if.tdata, 8'h96);
        flush_rx();

        // Loopback TX -> RX with 0x07
        perr0 = perr_cnt;
        lb_en = 1'b1;
        s_axis_if.tdata  = 8'h07;
        s_axis_if.tvalid = 1'b1;
        tick();
        s_axis_if.tvalid = 1'b0;
`ifdef UART_PARITY_EN
        repeat (9 * BAUD + 4) tick();
        chk1("lb_parity_bit", uart_txd, 1'b1);
`endif
        for (int g = 0; g < 20 * BAUD && !m_axis_if.tvalid; g++) tick();
        chk1("lb_tvalid", m_axis_if.tvalid, 1'b1);
        chk8("lb_tdata", m_axis_if.tdata, 8'h07);
        chkn("lb_perr", perr_cnt - perr0, 0);
        for (int g = 0; g < 20 * BAUD && !s_axis_if.tready; g++) tick();
        chk1("lb_tx_done", s_axis_if.tready, 1'b1);
        lb_en = 1'b0;
        flush_rx();
        repeat (4) tick();

`ifdef UART_PARITY_EN
        // 0x07 with parity bit forced to 0 (even parity requires 1)
        perr0 = perr_cnt;
        ferr0 = ferr_cnt;
        rxd_drv = 1'b0;
        repeat (BAUD) tick();
        for (int i = 0; i < 8; i++) begin
            rxd_drv = (i < 3) ? 1'b1 : 1'b0;
            repeat (BAUD) tick();
        end
        rxd_drv = 1'b0;
        repeat (BAUD) tick();
        rxd_drv = 1'b1;
        repeat (BAUD + 4) tick();
        chkn("badpar_perr", perr_cnt - perr0, 1);
        chkn("badpar_ferr", ferr_cnt - ferr0, 0);
        chk1("badpar_tvalid", m_axis_if.tvalid, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
